vga_scaled_timing: RTL and testbench
====================================

Name: vga_scaled_timing

Overview:
- Next-generation VGA output block for the NES emulator.
- Timing is fully parametrised: active size, porches, sync width and sync polarity are parameters.
- Supports a pixel-clock enable.
- Scales a SRC_W x SRC_H framebuffer by an integer SCALE, centred in the active area. Lines are repeated by address regeneration rather than a free-running index.
- Framebuffer read latency is a parameter; sync and colour outputs are pipeline-aligned to it.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, asserted level of VGA_H/VGA_V during sync
- SRC_W, 256, source framebuffer width
- SRC_H, 240, source framebuffer height
- SCALE, 2, integer magnification (1..4)
- RD_LAT, 1, framebuffer read latency in enabled cycles (>=1)
- COLOR_W, 4, bits per colour channel
- ADDR_W, 16, framebuffer address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- en  in  1  pixel-clock enable; all state advances only when en=1
- fb_addr  out  ADDR_W  framebuffer read address
- fb_rd  out  1  read strobe, high for in-window pixels
- fb_data  in  3*COLOR_W  {R,G,B} returned RD_LAT enabled cycles after fb_addr
- R  out  COLOR_W  red
- G  out  COLOR_W  green
- B  out  COLOR_W  blue
- VGA_H  out  1  horizontal sync
- VGA_V  out  1  vertical sync
- vblank  out  1  high while output line >= V_ACTIVE
- frame_start  out  1  one-enabled-cycle pulse coincident with output of pixel (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL likewise
  - H_OFF = (H_ACTIVE-SRC_W*SCALE)/2
  - V_OFF = (V_ACTIVE-SRC_H*SCALE)/2
  - Elaboration fails if either offset is negative, or if SRC_W*SRC_H > 2^ADDR_W.
- Reset (rst=0 at a clk edge), regardless of en:
  - h=v=0, sub-counters 0, row_base=0
  - fb_addr=0, fb_rd=0
  - R=G=B=0
  - VGA_H=VGA_V=~SYNC_POL
  - vblank=0, frame_start=0
  - All delay-line stages cleared to these inactive values.
- Counters:
  - h increments on en and wraps at H_TOTAL-1.
  - On h wrap, v increments and wraps at V_TOTAL-1.
- Window: active when H_OFF <= h < H_OFF+SRC_W*SCALE and V_OFF <= v < V_OFF+SRC_H*SCALE.
- Address generation (no multiplier):
  - xs counts 0..SCALE-1 inside the window; x_src increments when xs wraps.
  - At each line end inside the window, ys advances. When ys wraps, row_base += SRC_W.
  - x_src, xs, row_base and ys clear at window entry of frame (v = V_OFF, h = 0).
  - Stage 1 registers fb_addr = row_base + x_src and fb_rd = window, one enabled cycle after the counter state.
  - Outside the window fb_rd=0 and fb_addr holds.
- Output alignment:
  - RGB registers fb_data when the delayed window flag = 1, else 0.
  - Total latency from counter (h,v) to RGB/sync/vblank/frame_start is exactly RD_LAT+2 enabled cycles.
  - Sync and flags pass through a matching delay line.
- Sync:
  - VGA_H = SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - VGA_V uses the equivalent condition on v.
- en=0: every register holds, including outputs and the delay line. frame_start stays a single-enabled-cycle pulse.
- Reset mid-line or mid-frame: the next active frame restarts at (0,0) with address 0; no stale pixel is emitted.

Decomposition:
- Package vga_pkg holds:
  - default 640x480@60 timing constants
  - NES source size constants
  - an rgb_t struct of three COLOR_W fields
- One sub-module, vga_delay_line: parametric-depth, enable-gated shift register with synchronous active-low clear. Used for the sync, window, vblank and frame_start alignment.

Test Plan:
- Reset behaviour: hold rst=0 for 5 cycles with en=1, then release -> R/G/B=0, VGA_H=VGA_V=1 (SYNC_POL=0) and fb_rd=0 during reset. First frame_start occurs RD_LAT+2 cycles after release.
- Timing (defaults, en=1): VGA_H low for exactly 96 cycles per 800-cycle period. VGA_V low for exactly 2 lines per 525. vblank high for 45 lines per frame.
- Scaled addressing (defaults): on line 0, fb_rd rises at h=64, one cycle delayed. fb_addr sequence is 0,0,1,1,...,255,255 (512 reads); line 1 repeats 0..255; line 2 starts at 256; last read of the frame is 61439.
- Alignment with RD_LAT=3: the bench returns fb_data = {addr[11:0]}. The RGB pixel at output column 64 equals the data for address 0 at cycle h+5. Screen columns <64 and >=576 are black.
- Enable gating: en toggling 1,0,1,0 -> line period 1600 clk. The fb_addr sequence is identical to the en=1 case, and outputs never change on en=0 cycles.
- Reset mid-operation: assert rst at v=100, h=300, then release -> the address sequence restarts at 0 on the next frame. No fb_rd occurs before window entry.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the scaled VGA output path.
//   - default 640x480@60 timing (front porch, sync, back porch per axis)
//   - NES source framebuffer size and default scaling/latency/width values
//   - rgb_t: one {R,G,B} pixel with DEF_COLOR_W bits per channel
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_SYNC_POL = 1'b0;

    localparam int NES_W        = 256;
    localparam int NES_H        = 240;

    localparam int DEF_SCALE    = 2;
    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_COLOR_W  = 4;
    localparam int DEF_ADDR_W   = 16;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated shift register of DEPTH stages, W bits wide.
//   clk     in   system clock
//   rst     in   synchronous active-low clear, loads RST_VAL into every stage
//   en      in   shift enable; all stages hold while low
//   d       in   W-bit input to the first stage
//   q       out  W-bit output of the last stage (d delayed DEPTH enabled cycles)
module vga_delay_line #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr_q [DEPTH];
    logic [W-1:0] sr_d [DEPTH];

    always_comb begin
        sr_d[0] = en ? d : sr_q[0];
        for (int i = 1; i < DEPTH; i++) sr_d[i] = en ? sr_q[i-1] : sr_q[i];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= RST_VAL;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_scaled_timing.sv
// vga_scaled_timing: parametrised VGA timing generator that centres an
// integer-scaled SRC_W x SRC_H framebuffer in the active area.
//   clk          in   system clock
//   rst          in   synchronous active-low reset
//   en           in   pixel-clock enable; all state advances only when high
//   fb_addr      out  framebuffer read address (holds outside the window)
//   fb_rd        out  read strobe, high for in-window pixels
//   fb_data      in   {R,G,B} returned RD_LAT enabled cycles after fb_addr
//   R, G, B      out  colour, black outside the window
//   VGA_H/VGA_V  out  sync, SYNC_POL while asserted
//   vblank       out  high while the output line is below the active area
//   frame_start  out  one-enabled-cycle pulse with output pixel (0,0)
// Every output is RD_LAT+2 enabled cycles behind the (h,v) counters.
module vga_scaled_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL,
    parameter int SRC_W    = NES_W,
    parameter int SRC_H    = NES_H,
    parameter int SCALE    = DEF_SCALE,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic [ADDR_W-1:0]    fb_addr,
    output logic                 fb_rd,
    input  logic [3*COLOR_W-1:0] fb_data,
    output logic [COLOR_W-1:0]   R,
    output logic [COLOR_W-1:0]   G,
    output logic [COLOR_W-1:0]   B,
    output logic                 VGA_H,
    output logic                 VGA_V,
    output logic                 vblank,
    output logic                 frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SW      = SRC_W * SCALE;
    localparam int SH      = SRC_H * SCALE;
    localparam int H_OFF   = (H_ACTIVE - SW) / 2;
    localparam int V_OFF   = (V_ACTIVE - SH) / 2;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    if (H_ACTIVE < SW || V_ACTIVE < SH) begin : g_bad_offset
        $fatal(1, "scaled source image does not fit the active area");
    end
    if ((longint'(SRC_W) * SRC_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $fatal(1, "source framebuffer does not fit ADDR_W");
    end
    if (SCALE < 1 || SCALE > 4 || RD_LAT < 1) begin : g_bad_scale
        $fatal(1, "SCALE must be 1..4 and RD_LAT >= 1");
    end

    localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_OFF_C  = HW'(H_OFF);
    localparam logic [HW-1:0]     SW_C     = HW'(SW);
    localparam logic [HW-1:0]     H_WEND   = HW'(H_OFF + SW - 1);
    localparam logic [HW-1:0]     HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HS_LEN   = HW'(H_SYNC);
    localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_OFF_C  = VW'(V_OFF);
    localparam logic [VW-1:0]     SH_C     = VW'(SH);
    localparam logic [VW-1:0]     VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_LEN   = VW'(V_SYNC);
    localparam logic [VW-1:0]     V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [1:0]        SC_LAST  = 2'(SCALE - 1);
    localparam logic [ADDR_W-1:0] SRC_W_C  = ADDR_W'(SRC_W);

    logic [HW-1:0]        h_q, h_d;
    logic [VW-1:0]        v_q, v_d;
    logic [ADDR_W-1:0]    x_q, x_d, base_q, base_d, fb_addr_q, fb_addr_d;
    logic [1:0]           xs_q, xs_d, ys_q, ys_d;
    logic                 fb_rd_q, fb_rd_d;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;

    logic [HW-1:0]        hx, hsx;
    logic [VW-1:0]        vy, vsy;
    logic [ADDR_W-1:0]    x_c, base_c;
    logic [1:0]           xs_c, ys_c;
    logic                 win, line_end, frame_clr, hs, vs, vb, fs, win_dl;
    logic [3:0]           ctl_dl;

    always_comb begin
        // Offsets are subtracted modulo 2^W so "below the start" wraps to a
        // large value and a single unsigned compare covers both window edges.
        hx        = h_q - H_OFF_C;
        vy        = v_q - V_OFF_C;
        hsx       = h_q - HS_START;
        vsy       = v_q - VS_START;
        win       = (hx < SW_C) && (vy < SH_C);
        hs        = (hsx < HS_LEN) ? SYNC_POL : ~SYNC_POL;
        vs        = (vsy < VS_LEN) ? SYNC_POL : ~SYNC_POL;
        vb        = v_q >= V_ACT_C;
        fs        = (h_q == '0) && (v_q == '0);
        line_end  = win && (h_q == H_WEND);
        // The scaler state is zeroed at the first line of the window so a
        // frame always starts from address 0; zeroing is applied to the
        // value used this cycle, which also covers H_OFF = 0.
        frame_clr = en && (v_q == V_OFF_C) && (h_q == '0);
        x_c       = frame_clr ? '0 : x_q;
        xs_c      = frame_clr ? '0 : xs_q;
        ys_c      = frame_clr ? '0 : ys_q;
        base_c    = frame_clr ? '0 : base_q;
        h_d       = en ? ((h_q == H_LAST) ? '0 : h_q + 1'b1) : h_q;
        v_d       = (en && h_q == H_LAST) ? ((v_q == V_LAST) ? '0 : v_q + 1'b1) : v_q;
        x_d       = x_c;
        xs_d      = xs_c;
        ys_d      = ys_c;
        base_d    = base_c;
        if (en && line_end) begin
            x_d    = '0;
            xs_d   = '0;
            ys_d   = (ys_c == SC_LAST) ? '0 : ys_c + 1'b1;
            base_d = (ys_c == SC_LAST) ? base_c + SRC_W_C : base_c;
        end else if (en && win) begin
            xs_d   = (xs_c == SC_LAST) ? '0 : xs_c + 1'b1;
            x_d    = (xs_c == SC_LAST) ? x_c + 1'b1 : x_c;
        end
        fb_rd_d   = en ? win : fb_rd_q;
        fb_addr_d = (en && win) ? base_c + x_c : fb_addr_q;
        rgb_d     = en ? (win_dl ? fb_data : '0) : rgb_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q       <= '0;
            v_q       <= '0;
            x_q       <= '0;
            xs_q      <= '0;
            ys_q      <= '0;
            base_q    <= '0;
            fb_addr_q <= '0;
            fb_rd_q   <= 1'b0;
            rgb_q     <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            x_q       <= x_d;
            xs_q      <= xs_d;
            ys_q      <= ys_d;
            base_q    <= base_d;
            fb_addr_q <= fb_addr_d;
            fb_rd_q   <= fb_rd_d;
            rgb_q     <= rgb_d;
        end
    end

    // Sync/flags: counter stage, address stage, RD_LAT memory stages and the
    // RGB register give RD_LAT+2 stages in total.
    vga_delay_line #(
        .W       (4),
        .DEPTH   (RD_LAT + 2),
        .RST_VAL ({~SYNC_POL, ~SYNC_POL, 2'b00})
    ) u_ctl_dl (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   ({hs, vs, vb, fs}),
        .q   (ctl_dl)
    );

    // Window flag arrives together with fb_data, one stage before the RGB flop.
    vga_delay_line #(
        .W       (1),
        .DEPTH   (RD_LAT + 1),
        .RST_VAL (1'b0)
    ) u_win_dl (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (win),
        .q   (win_dl)
    );

    assign fb_addr                              = fb_addr_q;
    assign fb_rd                                = fb_rd_q;
    assign {R, G, B}                            = rgb_q;
    assign {VGA_H, VGA_V, vblank, frame_start}  = ctl_dl;

endmodule

// File: tb/tb_vga_scaled_timing.sv
// tb_vga_scaled_timing: self-checking bench for vga_scaled_timing on a reduced
// timing (56x31 total, 12x7 source scaled x3, RD_LAT=3) with a latency-modelled
// framebuffer and an arithmetic reference of the expected screen.
module tb_vga_scaled_timing;

    localparam int HA = 40, HF = 4, HSY = 6, HB = 6;
    localparam int VA = 24, VF = 2, VSY = 2, VB = 3;
    localparam int SW = 12, SH = 7, SC = 3, LAT = 3, CW = 4, AW = 8;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int HOFF = (HA - SW * SC) / 2;
    localparam int VOFF = (VA - SH * SC) / 2;
    localparam int L = LAT + 2;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0;
    logic [AW-1:0]   fb_addr;
    logic            fb_rd;
    logic [3*CW-1:0] fb_data;
    logic [CW-1:0]   R, G, B;
    logic            VGA_H, VGA_V, vblank, frame_start;
    logic [3*CW-1:0] rd_pipe [LAT];

    int pass_cnt = 0, tot_cnt = 0;
    int n = 0;
    logic [AW-1:0] m_addr = '0;

    vga_scaled_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .SYNC_POL(1'b0), .SRC_W(SW), .SRC_H(SH), .SCALE(SC),
        .RD_LAT(LAT), .COLOR_W(CW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .fb_addr(fb_addr), .fb_rd(fb_rd),
        .fb_data(fb_data), .R(R), .G(G), .B(B), .VGA_H(VGA_H), .VGA_V(VGA_V),
        .vblank(vblank), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pix(input int a);
        return 12'hA00 | 12'(a);
    endfunction

    // Framebuffer: data for the sampled address appears LAT enabled cycles later.
    always @(posedge clk) begin
        if (en) begin
            rd_pipe[0] <= pix(int'(fb_addr));
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign fb_data = rd_pipe[LAT-1];

    function automatic bit win_at(input int t);
        int h, v;
        h = t % HT;
        v = (t / HT) % VT;
        return h >= HOFF && h < HOFF + SW * SC && v >= VOFF && v < VOFF + SH * SC;
    endfunction

    function automatic int addr_at(input int t);
        int h, v;
        h = t % HT;
        v = (t / HT) % VT;
        return ((v - VOFF) / SC) * SW + (h - HOFF) / SC;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (n=%0d)", name, got, exp, n);
    endtask

    task automatic model_check();
        int to, h, v;
        logic e_rd, e_hs, e_vs, e_vb, e_fs;
        logic [11:0] e_rgb;
        e_rd  = (n >= 1) && win_at(n - 1);
        e_hs  = 1'b1;
        e_vs  = 1'b1;
        e_vb  = 1'b0;
        e_fs  = 1'b0;
        e_rgb = 12'h000;
        if (n >= L) begin
            to    = n - L;
            h     = to % HT;
            v     = (to / HT) % VT;
            e_hs  = !(h >= HA + HF && h < HA + HF + HSY);
            e_vs  = !(v >= VA + VF && v < VA + VF + VSY);
            e_vb  = v >= VA;
            e_fs  = (h == 0) && (v == 0);
            e_rgb = win_at(to) ? pix(addr_at(to)) : 12'h000;
        end
        check("model_ctl", 32'({fb_rd, fb_addr, VGA_H, VGA_V, vblank, frame_start}),
              32'({e_rd, m_addr, e_hs, e_vs, e_vb, e_fs}));
        check("model_rgb", 32'({R, G, B}), 32'(e_rgb));
    endtask

    // One clock: drive inputs, advance the reference on the sampled edge, compare.
    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        if (!r) begin
            n      = 0;
            m_addr = '0;
        end else if (e) begin
            n++;
            if (win_at(n - 1)) m_addr = AW'(addr_at(n - 1));
        end
        model_check();
    endtask

    typedef struct {
        logic        r;
        logic        e;
        int          cyc;
        logic        rd;
        logic [7:0]  addr;
        logic        hs, vs, vb, fs;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl [14];

    initial begin
        // Cumulative from reset; enabled-cycle count n noted after each row.
        tbl[0]  = '{1'b0, 1'b1, 5,    1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000}; // in reset
        tbl[1]  = '{1'b1, 1'b1, 4,    1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000}; // n=4
        tbl[2]  = '{1'b1, 1'b1, 1,    1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000}; // n=5 frame_start
        tbl[3]  = '{1'b1, 1'b0, 3,    1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000}; // en=0 hold
        tbl[4]  = '{1'b1, 1'b1, 1,    1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000}; // n=6
        tbl[5]  = '{1'b1, 1'b1, 43,   1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000}; // hsync starts
        tbl[6]  = '{1'b1, 1'b1, 6,    1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000}; // hsync ends
        tbl[7]  = '{1'b1, 1'b1, 4,    1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000}; // first read
        tbl[8]  = '{1'b1, 1'b1, 3,    1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000}; // x_src=1
        tbl[9]  = '{1'b1, 1'b1, 2,    1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 12'hA00}; // first pixel out
        tbl[10] = '{1'b1, 1'b1, 32,   1'b0, 8'h0B, 1'b1, 1'b1, 1'b0, 1'b0, 12'hA0B}; // addr holds
        tbl[11] = '{1'b1, 1'b1, 131,  1'b1, 8'h0C, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000}; // second row
        tbl[12] = '{1'b1, 1'b1, 1234, 1'b0, 8'h53, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000}; // vsync
        tbl[13] = '{1'b0, 1'b0, 1,    1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000}; // reset, en=0
        for (int i = 0; i < 14; i++) begin
            for (int c = 0; c < tbl[i].cyc; c++) step(tbl[i].r, tbl[i].e);
            check($sformatf("vec%0d_ctl", i),
                  32'({fb_rd, fb_addr, VGA_H, VGA_V, vblank, frame_start}),
                  32'({tbl[i].rd, tbl[i].addr, tbl[i].hs, tbl[i].vs, tbl[i].vb, tbl[i].fs}));
            check($sformatf("vec%0d_rgb", i), 32'({R, G, B}), 32'(tbl[i].rgb));
        end

        // en toggling 1,0,...: line period doubles, hsync low for twice H_SYNC clocks.
        begin
            int t0, t1, lowc;
            logic prev;
            t0 = -1; t1 = -1; lowc = 0; prev = 1'b1;
            step(1'b0, 1'b1);
            for (int c = 0; c < 6 * HT && t1 < 0; c++) begin
                step(1'b1, (c % 2) == 0);
                if (prev && !VGA_H) begin
                    if (t0 < 0) t0 = c;
                    else t1 = c;
                end
                if (t0 >= 0 && t1 < 0 && !VGA_H) lowc++;
                prev = VGA_H;
            end
            check("en_line_period", 32'(t1 - t0), 32'(2 * HT));
            check("en_hsync_low", 32'(lowc), 32'(2 * HSY));
        end

        // One full frame with en=1: read count, first read position, last address.
        begin
            int rdc, first, last;
            rdc = 0; first = -1; last = 0;
            step(1'b0, 1'b1);
            for (int c = 1; c <= HT * VT; c++) begin
                step(1'b1, 1'b1);
                if (fb_rd) begin
                    rdc++;
                    if (first < 0) first = c;
                    last = int'(fb_addr);
                end
            end
            check("frame_reads", 32'(rdc), 32'(SW * SH * SC * SC));
            check("frame_first_rd", 32'(first), 32'(VOFF * HT + HOFF + 1));
            check("frame_last_addr", 32'(last), 32'(SW * SH - 1));
        end

        // Reset mid-frame (v=10, h=30): next frame restarts from address 0.
        begin
            int first, faddr;
            first = -1; faddr = -1;
            for (int c = 0; c < 10 * HT + 30; c++) step(1'b1, 1'b1);
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            for (int c = 1; c <= 2 * HT * VT && first < 0; c++) begin
                step(1'b1, 1'b1);
                if (fb_rd) begin
                    first = c;
                    faddr = int'(fb_addr);
                end
            end
            check("midrst_first_rd", 32'(first), 32'(VOFF * HT + HOFF + 1));
            check("midrst_first_addr", 32'(faddr), 32'(0));
        end

        // Randomised enable and occasional reset against the reference.
        for (int c = 0; c < 20000; c++)
            step($urandom_range(0, 3999) != 0, $urandom_range(0, 3) != 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
